// File: rtl/call_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : call_dispatch
// Brief    : Hall-call latch and nearest-floor dispatcher for a single lift car.
//            Optional acceptance timeout enabled by macro CALL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module call_dispatch #(
    parameter int NUM_FLOORS  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    input  logic [2:0]            elev_f_i,
    input  logic                  busy_i,
    output logic [2:0]            pass_f_o,
    output logic                  call_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [2:0]              pass_f_q, pass_f_d;
    logic                    call_q, call_d;
    logic [NUM_FLOORS-1:0]   clr;
    logic [NUM_FLOORS-1:0]   pass_onehot;
    logic [2:0]              sel_f;
    logic [3:0]              sel_dist;
    logic [3:0]              cand_dist;

`ifdef CALL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    // Ascending scan with strict less-than keeps the lower index on a tie.
    always_comb begin
        sel_f     = 3'd0;
        sel_dist  = 4'hF;
        cand_dist = 4'h0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (4'(i) >= {1'b0, elev_f_i})
                cand_dist = 4'(i) - {1'b0, elev_f_i};
            else
                cand_dist = {1'b0, elev_f_i} - 4'(i);
            if (pending_q[i] && (cand_dist < sel_dist)) begin
                sel_dist = cand_dist;
                sel_f    = 3'(i);
            end
        end
    end

    always_comb begin
        pass_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            pass_onehot[i] = (pass_f_q == 3'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        pass_f_d = pass_f_q;
        call_d   = call_q;
        clr      = '0;
`ifdef CALL_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                call_d = 1'b0;
                if ((|pending_q) && !busy_i) begin
                    pass_f_d = sel_f;
                    call_d   = 1'b1;
                    state_d  = S_ISSUE;
`ifdef CALL_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (busy_i) begin
                    call_d  = 1'b0;
                    clr     = pass_onehot;
                    state_d = S_SERVE;
                end
`ifdef CALL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Give up on this issue; the pending bit stays for reselection.
                    call_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_SERVE: begin
                call_d = 1'b0;
                if (!busy_i)
                    state_d = S_IDLE;
            end
            default: begin
                call_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        pending_d = (pending_q & ~clr) | call_req_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            pass_f_q  <= 3'd0;
            call_q    <= 1'b0;
`ifdef CALL_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pass_f_q  <= pass_f_d;
            call_q    <= call_d;
`ifdef CALL_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign pass_f_o  = pass_f_q;
    assign call_o    = call_q;
    assign pending_o = pending_q;
`ifdef CALL_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0 & (TIMEOUT_CYC > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_call_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_dispatch
// Brief    : Self-checking bench for call_dispatch against a rule-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_call_dispatch;

    localparam int c_floors = 8;
    localparam int c_tmo    = 4;

    logic                clk;
    logic                rst_n;
    logic [c_floors-1:0] call_req_i;
    logic [2:0]          elev_f_i;
    logic                busy_i;
    logic [2:0]          pass_f_o;
    logic                call_o;
    logic [c_floors-1:0] pending_o;
    logic                timeout_o;

    int n_checks;
    int n_fail;

    // Reference model: requests as a set, the lift dialogue as three flags.
    bit [c_floors-1:0] m_pend;
    bit                m_waiting;
    bit                m_serving;
    bit                m_call;
    bit                m_to;
    int                m_tgt;
    int                m_wait;

    call_dispatch #(
        .NUM_FLOORS  (c_floors),
        .TIMEOUT_CYC (c_tmo)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .call_req_i (call_req_i),
        .elev_f_i   (elev_f_i),
        .busy_i     (busy_i),
        .pass_f_o   (pass_f_o),
        .call_o     (call_o),
        .pending_o  (pending_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Search outward from the car; the lower floor is tried first at each radius.
    function automatic int nearest(input bit [c_floors-1:0] set, input int car);
        for (int r = 0; r < 2 * c_floors; r++) begin
            if (car - r >= 0 && car - r < c_floors && set[car - r]) return car - r;
            if (car + r < c_floors && set[car + r]) return car + r;
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit [c_floors-1:0] clr;
        clr  = '0;
        m_to = 1'b0;
        if (!rst_n) begin
            m_pend = '0; m_waiting = 0; m_serving = 0; m_call = 0; m_tgt = 0; m_wait = 0;
        end else begin
            if (m_serving) begin
                if (!busy_i) m_serving = 0;
            end else if (m_waiting) begin
                if (busy_i) begin
                    clr[m_tgt] = 1'b1;
                    m_waiting  = 0;
                    m_serving  = 1;
                    m_call     = 0;
                end else begin
`ifdef CALL_TIMEOUT_EN
                    m_wait++;
                    if (m_wait == c_tmo) begin
                        m_waiting = 0;
                        m_call    = 0;
                        m_to      = 1;
                    end
`endif
                end
            end else if (m_pend != 0 && !busy_i) begin
                m_tgt     = nearest(m_pend, int'(elev_f_i));
                m_waiting = 1;
                m_call    = 1;
                m_wait    = 0;
            end
            m_pend = (m_pend & ~clr) | call_req_i;
        end
    endtask

    task automatic step(input logic rn, input logic [7:0] req, input logic [2:0] elev,
                        input logic busy);
        rst_n      = rn;
        call_req_i = req;
        elev_f_i   = elev;
        busy_i     = busy;
        @(posedge clk);
        model_edge();
        #1;
        check("pending", 32'(pending_o), 32'(m_pend));
        check("call",    32'(call_o),    32'(m_call));
        check("pass_f",  32'(pass_f_o),  32'(m_tgt));
        check("timeout", 32'(timeout_o), 32'(m_to));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_pend = '0; m_waiting = 0; m_serving = 0; m_call = 0; m_to = 0; m_tgt = 0; m_wait = 0;
        rst_n = 1'b0; call_req_i = '0; elev_f_i = '0; busy_i = 1'b0;

        // Reset with all buttons pressed.
        step(0, 8'hFF, 3'd0, 0);
        step(0, 8'hFF, 3'd0, 0);
        check("rst_pending", 32'(pending_o), 32'h0);
        check("rst_call",    32'(call_o),    32'h0);
        check("rst_pass",    32'(pass_f_o),  32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);

        // Single call to floor 5 from floor 1.
        step(1, 8'h20, 3'd1, 0);
        check("single_call_lat1", 32'(call_o), 32'h0);
        step(1, 8'h00, 3'd1, 0);
        check("single_call_lat2", 32'(call_o), 32'h1);
        check("single_pass",      32'(pass_f_o), 32'h5);
        step(1, 8'h00, 3'd1, 1);
        check("single_accept_call", 32'(call_o), 32'h0);
        check("single_accept_clr",  32'(pending_o[5]), 32'h0);
        step(1, 8'h00, 3'd1, 0);

        // Tie at distance 2 from floor 4: lower floor wins.
        step(0, 8'h00, 3'd4, 0);
        step(1, 8'h44, 3'd4, 1);
        step(1, 8'h00, 3'd4, 0);
        check("tie_2_6", 32'(pass_f_o), 32'h2);
        step(0, 8'h00, 3'd4, 0);
        step(1, 8'h88, 3'd4, 1);
        step(1, 8'h00, 3'd4, 0);
        check("near_3_7", 32'(pass_f_o), 32'h3);

        // Busy hold-off in idle.
        step(0, 8'h00, 3'd2, 0);
        step(1, 8'h01, 3'd2, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h00, 3'd2, 1);
            check("holdoff_call", 32'(call_o), 32'h0);
        end
        step(1, 8'h00, 3'd2, 0);
        check("holdoff_release", 32'(call_o), 32'h1);
        check("holdoff_pass",    32'(pass_f_o), 32'h0);

        // Re-latch of the floor being cleared on the accept edge.
        step(0, 8'h00, 3'd0, 0);
        step(1, 8'h08, 3'd0, 0);
        step(1, 8'h00, 3'd0, 0);
        check("relatch_issue", 32'(pass_f_o), 32'h3);
        step(1, 8'h08, 3'd0, 1);
        check("relatch_pending", 32'(pending_o[3]), 32'h1);
        check("relatch_call",    32'(call_o), 32'h0);
        step(1, 8'h00, 3'd0, 0);

`ifdef CALL_TIMEOUT_EN
        // Floor 6 never accepted.
        step(0, 8'h00, 3'd6, 0);
        step(1, 8'h40, 3'd6, 0);
        step(1, 8'h00, 3'd6, 0);
        check("tmo_issue", 32'(call_o), 32'h1);
        for (int i = 0; i < c_tmo - 1; i++) begin
            step(1, 8'h00, 3'd6, 0);
            check("tmo_wait_call", 32'(call_o), 32'h1);
        end
        step(1, 8'h00, 3'd6, 0);
        check("tmo_call_drop", 32'(call_o), 32'h0);
        check("tmo_pulse",     32'(timeout_o), 32'h1);
        check("tmo_keep",      32'(pending_o[6]), 32'h1);
        step(1, 8'h00, 3'd6, 0);
        check("tmo_pulse_end", 32'(timeout_o), 32'h0);
        check("tmo_reissue",   32'(call_o), 32'h1);
        check("tmo_repass",    32'(pass_f_o), 32'h6);
        step(1, 8'h00, 3'd6, 1);
        step(1, 8'h00, 3'd6, 0);
`endif

        // Reset during service with floors 0 and 7 pending.
        step(0, 8'h00, 3'd0, 0);
        step(1, 8'h81, 3'd0, 0);
        step(1, 8'h00, 3'd0, 0);
        step(1, 8'h81, 3'd0, 1);
        check("midrst_pre", 32'(pending_o), 32'h81);
        step(0, 8'h00, 3'd0, 1);
        check("midrst_pending", 32'(pending_o), 32'h0);
        check("midrst_call",    32'(call_o), 32'h0);
        step(1, 8'h04, 3'd0, 0);
        step(1, 8'h00, 3'd0, 0);
        check("midrst_idle_call", 32'(call_o), 32'h1);
        check("midrst_idle_pass", 32'(pass_f_o), 32'h2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rq;
            logic       bz;
            logic       rn;
            rq = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 9) == 0) rq = rq | 8'($urandom);
            bz = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 79) != 0);
            step(rn, rq, 3'($urandom_range(0, 7)), bz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_dispatch.md
CALL_DISPATCH -- requirements
Module: call_dispatch

Interface
REQ-001 The block SHALL have parameter NUM_FLOORS, default 8, giving the number of served floors (2..8), indexed 0..NUM_FLOORS-1 on 3 bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16, giving the acceptance timeout in cycles; it is used only under REQ-024.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port call_req_i, input, NUM_FLOORS bits: hall-call buttons, one bit per floor, sampled as a level every cycle.
REQ-006 The block SHALL have port elev_f_i, input, 3 bits: the current lift-car floor.
REQ-007 The block SHALL have port busy_i, input, 1 bit: lift status (1 = busy / serving, 0 = free).
REQ-008 The block SHALL have port pass_f_o, output, 3 bits: the target floor issued to the lift.
REQ-009 The block SHALL have port call_o, output, 1 bit: call strobe to the lift; it drives the lift's up/down call input.
REQ-010 The block SHALL have port pending_o, output, NUM_FLOORS bits: the registered pending-call bitmap.
REQ-011 The block SHALL have port timeout_o, output, 1 bit: a one-cycle pulse on acceptance timeout.

Function
REQ-012 The pending register SHALL update every cycle as pending <= (pending & ~clr) | call_req_i.
- clr is the one-hot clear of REQ-017.
- Set wins over clear in the same cycle.
- A request becomes visible on pending_o one cycle after it is sampled.
REQ-013 The FSM SHALL have exactly three states, IDLE, ISSUE and SERVE, encoded in 2 bits; any illegal encoding SHALL return to IDLE on the next edge.
REQ-014 In IDLE, when pending != 0 and busy_i == 0, the block SHALL:
- register the selected target into pass_f_o;
- set call_o <= 1;
- go to ISSUE.
Otherwise it SHALL stay in IDLE with call_o = 0.
REQ-015 Target selection SHALL choose, from the registered pending bitmap only, the index i with minimum |i - elev_f_i|.
- Compute the difference on 4-bit unsigned magnitude, with no wrap.
- On a tie, choose the lower index.
- A pending bit at i == elev_f_i is a legal target with distance 0.
REQ-016 In ISSUE, call_o SHALL stay 1 and pass_f_o SHALL stay constant until busy_i == 1 is sampled.
REQ-017 On sampling busy_i == 1 in ISSUE, the block SHALL:
- set call_o <= 0;
- clear pending[pass_f_o] on that same edge;
- go to SERVE.
REQ-018 In SERVE, the block SHALL stay until busy_i == 0 is sampled, then go to IDLE; a new selection happens at the earliest on the following edge.
REQ-019 pass_f_o SHALL hold its last value outside ISSUE and change only on the IDLE->ISSUE transition.
REQ-020 A call_req_i bit for the floor being cleared in that cycle SHALL re-latch as pending; it SHALL NOT be lost.
REQ-021 Best-case latency from a request sampled at edge k, with the block in IDLE and busy_i = 0, to call_o = 1 SHALL be 2 edges (call_o is high after edge k+1).

Reset
REQ-022 While rst_n == 0 at a clk edge, the block SHALL reset:
- state -> IDLE;
- pending -> 0;
- pass_f_o -> 0;
- call_o -> 0;
- timeout_o -> 0;
- timeout counter -> 0.
REQ-023 A reset in ISSUE or SERVE SHALL drop call_o at that edge and discard all pending calls; call_req_i is ignored while rst_n == 0.

Configuration
REQ-024 With macro CALL_TIMEOUT_EN defined, the block SHALL behave as follows:
- An ISSUE-state counter starts at 0 on entry.
- If busy_i is not sampled high within TIMEOUT_CYC cycles of call_o rising, the block sets call_o <= 0, pulses timeout_o for exactly 1 cycle, keeps the pending bit and returns to IDLE.
- On reselection, the block again applies REQ-015.
REQ-025 Without CALL_TIMEOUT_EN, ISSUE SHALL wait indefinitely, no counter logic SHALL be present, and timeout_o SHALL be constant 0.

Verification
REQ-026 Reset-value check: hold rst_n = 0 for 2 cycles with call_req_i = 8'hFF -> pending_o = 0, call_o = 0, pass_f_o = 0, timeout_o = 0.
REQ-027 Single call: elev_f_i = 1, busy_i = 0, pulse call_req_i[5] for 1 cycle -> call_o = 1 two edges later with pass_f_o = 5; then raise busy_i -> call_o = 0 and pending_o[5] = 0 next edge.
REQ-028 Nearest-floor selection and tie-break:
- pending = {2, 6}, elev_f_i = 4, busy_i = 0 -> pass_f_o = 2.
- pending = {3, 7}, elev_f_i = 4 -> pass_f_o = 3.
REQ-029 Busy hold-off and re-latch:
- busy_i = 1 in IDLE with pending_o[0] = 1 -> call_o stays 0 until busy_i = 0.
- In ISSUE for floor 3, assert call_req_i[3] on the accept edge -> pending_o[3] = 1 after that edge.
REQ-030 Timeout (CALL_TIMEOUT_EN, TIMEOUT_CYC = 4): issue floor 6 and hold busy_i = 0 -> call_o falls after 4 cycles, timeout_o pulses 1 cycle, pending_o[6] stays 1, call_o re-asserts with pass_f_o = 6.
REQ-031 Mid-operation reset: assert rst_n = 0 during SERVE with pending = 8'h81 -> next edge pending_o = 0, call_o = 0, and the block returns to IDLE.
